// File: rtl/word_uart_tx_if.sv
// Push-side bus for word_uart_tx: one word per int_send && int_ready handshake.
// Latency: none (wires only); int_ready is registered inside the transmitter.
// Backpressure: the producer must hold off while int_ready is low, otherwise the word is dropped.
interface word_uart_tx_if #(
    parameter int WORD_BYTES = 4
);
    logic [8*WORD_BYTES-1:0] data;
    logic                    int_send;
    logic                    int_ready;

    modport master (output data, output int_send, input int_ready);
    modport slave  (input data, input int_send, output int_ready);
endinterface

// File: rtl/word_uart_tx.sv
// Buffered UART transmitter: DEPTH-word FIFO feeding an N-byte 8N1 serialiser (LSB of each byte first).
// Latency: a push into an empty idle block drives the start bit 3 cycles after the push edge.
// Backpressure: int_ready drops while the FIFO holds DEPTH words; pushes during that time are ignored.
// Optional WORD_UART_TX_CHECKSUM_EN appends one XOR-of-all-bytes frame after every word.
module word_uart_tx #(
    parameter int CLKS_PER_BIT = 234,
    parameter int WORD_BYTES   = 4,
    parameter int DEPTH        = 4,
    parameter int MSB_FIRST    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    word_uart_tx_if.slave          push,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int DW = 8 * WORD_BYTES;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
`ifdef WORD_UART_TX_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level_nxt;
    logic          int_ready_q;
    logic          push_fire, pop;
    logic [DW-1:0] word_q;
    logic [BW-1:0] baud_cnt, baud_nxt;
    logic [3:0]    bit_idx, bit_nxt;
    logic [2:0]    byte_idx, byte_nxt, byte_sel;
    logic [7:0]    cur_byte;
    logic          bit_end, tx_nxt;

`ifdef WORD_UART_TX_CHECKSUM_EN
    logic [7:0] csum_q;

    function automatic logic [7:0] xor_bytes(input logic [DW-1:0] w);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < WORD_BYTES; i++) acc ^= w[8*i +: 8];
        return acc;
    endfunction
`endif

    assign push.int_ready = int_ready_q;
    assign push_fire      = push.int_send && int_ready_q;
    assign busy           = (state != S_IDLE) || (level != '0);
    assign bit_end        = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    assign byte_sel       = (MSB_FIRST != 0) ? (3'(WORD_BYTES - 1) - byte_idx) : byte_idx;
    assign cur_byte       = 8'(word_q >> {byte_sel, 3'b000});

    // A pop only happens in LOAD, which is entered only with level != 0.
    always_comb begin
        level_nxt = level;
        if (push_fire && !pop)      level_nxt = level + 1'b1;
        else if (pop && !push_fire) level_nxt = level - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_fire) mem[wr_ptr] <= push.data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            int_ready_q <= 1'b1;
            tx          <= 1'b1;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            word_q      <= '0;
`ifdef WORD_UART_TX_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state       <= state_nxt;
            level       <= level_nxt;
            int_ready_q <= (level_nxt != FULL_LVL);
            tx          <= tx_nxt;
            baud_cnt    <= baud_nxt;
            bit_idx     <= bit_nxt;
            byte_idx    <= byte_nxt;
            if (push_fire) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                word_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
`ifdef WORD_UART_TX_CHECKSUM_EN
                csum_q <= xor_bytes(mem[rd_ptr]);
`endif
            end
        end
    end

    // tx is registered from the current state, so the line trails the FSM by one cycle.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        tx_nxt    = 1'b1;
        baud_nxt  = '0;
        bit_nxt   = bit_idx;
        byte_nxt  = byte_idx;
        if (state != S_IDLE && state != S_LOAD)
            baud_nxt = bit_end ? '0 : baud_cnt + 1'b1;
        case (state)
            S_IDLE: begin
                if (level != '0) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                pop       = 1'b1;
                byte_nxt  = '0;
                bit_nxt   = '0;
                state_nxt = S_START;
            end
            S_START: begin
                tx_nxt = 1'b0;
                if (bit_end) begin
                    bit_nxt   = '0;
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                tx_nxt = cur_byte[bit_idx[2:0]];
                if (bit_end) begin
                    if (bit_idx == 4'd7) state_nxt = S_STOP;
                    else                 bit_nxt   = bit_idx + 4'd1;
                end
            end
            S_STOP: begin
                tx_nxt = 1'b1;
                if (bit_end) begin
                    if (byte_idx == 3'(WORD_BYTES - 1)) begin
`ifdef WORD_UART_TX_CHECKSUM_EN
                        bit_nxt   = '0;
                        state_nxt = S_CHK;
`else
                        state_nxt = S_IDLE;
`endif
                    end else begin
                        byte_nxt  = byte_idx + 3'd1;
                        state_nxt = S_START;
                    end
                end
            end
`ifdef WORD_UART_TX_CHECKSUM_EN
            // Whole checksum frame in one state: index 0 start, 1..8 data, 9 stop.
            S_CHK: begin
                if (bit_idx == 4'd0)      tx_nxt = 1'b0;
                else if (bit_idx == 4'd9) tx_nxt = 1'b1;
                else                      tx_nxt = csum_q[3'(bit_idx - 4'd1)];
                if (bit_end) begin
                    if (bit_idx == 4'd9) state_nxt = S_IDLE;
                    else                 bit_nxt   = bit_idx + 4'd1;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_word_uart_tx.sv
// Bench for word_uart_tx: timing-arithmetic reference model checked every cycle, plus directed literal checks.
// Honours WORD_UART_TX_CHECKSUM_EN when the design is built with it.
`timescale 1ns/1ps
module tb_word_uart_tx;
    localparam int CPB   = 4;
    localparam int WB    = 4;
    localparam int DEPTH = 4;
    localparam int MSB   = 0;
`ifdef WORD_UART_TX_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif
    localparam int F    = (WB + CHK) * 10 * CPB;
    localparam int F2   = (2 + CHK) * 10 * CPB;
    localparam int MAXW = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx, busy, tx2, busy2;
    logic [2:0] level, level2;

    word_uart_tx_if #(.WORD_BYTES(WB)) bus ();
    word_uart_tx_if #(.WORD_BYTES(2))  bus2 ();

    word_uart_tx #(.CLKS_PER_BIT(CPB), .WORD_BYTES(WB), .DEPTH(DEPTH), .MSB_FIRST(MSB)) dut (
        .clk(clk), .rst(rst), .push(bus), .tx(tx), .busy(busy), .level(level));
    word_uart_tx #(.CLKS_PER_BIT(CPB), .WORD_BYTES(2), .DEPTH(4), .MSB_FIRST(1)) dut2 (
        .clk(clk), .rst(rst), .push(bus2), .tx(tx2), .busy(busy2), .level(level2));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    // Expected line level at a given offset into a word's transmission.
    function automatic logic exp_bit(input logic [31:0] w, input int off);
        int bp, k, j;
        logic [7:0] b;
        bp = off / CPB;
        k  = bp / 10;
        j  = bp % 10;
        if (k < WB) b = 8'(w >> (8 * ((MSB != 0) ? (WB - 1 - k) : k)));
        else        b = w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j - 1];
    endfunction

    // Model: each accepted word gets a load edge L = max(push edge, previous word's idle edge) + 1;
    // it leaves the FIFO at L+1, the line carries it after edges L+2 .. L+1+F, and the FSM idles at L+1+F.
    logic [31:0] w_dat  [MAXW];
    int          w_push [MAXW];
    int          w_load [MAXW];
    int          base = 0, nw = 0, e_last = 0;
    logic        m_tx = 1'b1, m_ready = 1'b1, m_busy = 1'b0;
    int          m_level = 0;

    initial begin
        int   lvl;
        logic act, txv;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                base   = nw;
                e_last = cyc;
            end else if (bus.int_send && m_ready) begin
                if (nw < MAXW) begin
                    w_dat[nw]  = bus.data;
                    w_push[nw] = cyc;
                    w_load[nw] = ((cyc > e_last) ? cyc : e_last) + 1;
                    e_last     = w_load[nw] + 1 + F;
                    nw++;
                end else begin
                    miscompares++;
                    $display("FAIL model_capacity at cycle %0d: got %0d words, limit %0d", cyc, nw, MAXW);
                end
            end
            lvl = 0;
            act = 1'b0;
            txv = 1'b1;
            for (int i = base; i < nw; i++) begin
                if (w_push[i] <= cyc && cyc < w_load[i] + 1) lvl++;
                if (w_load[i] <= cyc && cyc < w_load[i] + 1 + F) act = 1'b1;
                if (cyc >= w_load[i] + 2 && cyc < w_load[i] + 2 + F)
                    txv = exp_bit(w_dat[i], cyc - w_load[i] - 2);
            end
            m_level = lvl;
            m_ready = (lvl != DEPTH);
            m_busy  = act || (lvl != 0);
            m_tx    = txv;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("tx", 64'(tx), 64'(m_tx));
                check("int_ready", 64'(bus.int_ready), 64'(m_ready));
                check("busy", 64'(busy), 64'(m_busy));
                check("level", 64'(level), 64'(m_level));
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_tx_low(input int sel, output int s);
        int n;
        n = 0;
        s = -1;
        while (n < 64) begin
            @(negedge clk);
            n++;
            if (((sel == 0) ? tx : tx2) == 1'b0) begin
                s = cyc;
                break;
            end
        end
        check("start_timeout", 64'(s >= 0), 64'd1);
    endtask

    // Byte k of the stream lands in got[8k +: 8]; framing bits are checked as they pass.
    task automatic read_frame(input int sel, input int s, input int nb, output logic [63:0] got);
        logic v;
        got = '0;
        for (int k = 0; k < nb; k++) begin
            for (int j = 0; j < 10; j++) begin
                wait_cyc(s + (10 * k + j) * CPB + CPB / 2);
                v = (sel == 0) ? tx : tx2;
                if (j == 0)      check("start_bit", 64'(v), 64'd0);
                else if (j == 9) check("stop_bit", 64'(v), 64'd1);
                else             got[8 * k + j - 1] = v;
            end
        end
    endtask

    task automatic push1(input logic [31:0] d, output int p);
        bus.data     = d;
        bus.int_send = 1'b1;
        @(negedge clk);
        bus.int_send = 1'b0;
        p = cyc;
    endtask

    initial begin
        int          p, s, rate;
        logic [63:0] got;
        bus.data      = '0;
        bus.int_send  = 1'b0;
        bus2.data     = '0;
        bus2.int_send = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_tx", 64'(tx), 64'd1);
        check("reset_ready", 64'(bus.int_ready), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_level", 64'(level), 64'd0);
        check("reset2_state", {tx2, bus2.int_ready, busy2, level2}, {1'b1, 1'b1, 1'b0, 3'd0});
        rst    = 1'b0;
        chk_en = 1'b1;

        // Single word, LSB byte first: DD CC BB AA.
        push1(32'hAABBCCDD, p);
        wait_tx_low(0, s);
        check("latency", 64'(s - p), 64'd3);
        read_frame(0, s, WB, got);
        check("lsb_first_bytes", got, 64'h00000000AABBCCDD);
        wait_cyc(s + F - 2);
        check("busy_before_end", 64'(busy), 64'd1);
        wait_cyc(s + F - 1);
        check("busy_fall", 64'(busy), 64'd0);
        check("level_after", 64'(level), 64'd0);
        wait_idle();

        // MSB-first instance, 2-byte word: 7D then 58.
        bus2.data     = 16'h7D58;
        bus2.int_send = 1'b1;
        @(negedge clk);
        bus2.int_send = 1'b0;
        p = cyc;
        wait_tx_low(1, s);
        check("latency2", 64'(s - p), 64'd3);
        read_frame(1, s, 2, got);
        check("msb_first_bytes", got, 64'h000000000000587D);
        wait_cyc(s + F2 + 4);
        check("busy2_done", 64'(busy2), 64'd0);

`ifdef WORD_UART_TX_CHECKSUM_EN
        push1(32'h01020304, p);
        wait_tx_low(0, s);
        read_frame(0, s, 5, got);
        check("checksum_frame", got, 64'h0000000401020304);
        wait_idle();
`endif

        // Six back-to-back pushes: five accepted, the sixth meets int_ready low.
        bus.int_send = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.data = 32'h11110000 + i;
            @(negedge clk);
            if (i == 4) begin
                check("full_ready", 64'(bus.int_ready), 64'd0);
                check("full_level", 64'(level), 64'd4);
            end
        end
        bus.int_send = 1'b0;
        check("full_drop_level", 64'(level), 64'd4);
        wait_idle();

        // Push landing on the same edge as the pop: level holds at 1.
        push1(32'hCAFEF00D, p);
        @(negedge clk);
        push1(32'h12345678, p);
        check("push_pop_level", 64'(level), 64'd1);
        wait_idle();

        // Reset during data bit 3 of byte 1, with a second word queued.
        push1(32'h55AA33CC, p);
        push1(32'h99887766, p);
        wait_tx_low(0, s);
        wait_cyc(s + 14 * CPB + 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_tx", 64'(tx), 64'd1);
        check("abort_level", 64'(level), 64'd0);
        check("abort_ready", 64'(bus.int_ready), 64'd1);
        push1(32'h0F1E2D3C, p);
        wait_tx_low(0, s);
        check("latency_after_abort", 64'(s - p), 64'd3);
        read_frame(0, s, WB, got);
        check("clean_frame", got, 64'h000000000F1E2D3C);
        wait_idle();

        // Random traffic with varying push density and rare resets.
        for (int blk = 0; blk < 8; blk++) begin
            rate = $urandom_range(1, 300);
            for (int c = 0; c < 500; c++) begin
                bus.data     = $urandom;
                bus.int_send = ($urandom_range(1, rate) == 1);
                rst          = ($urandom_range(0, 999) == 0);
                @(negedge clk);
            end
        end
        bus.int_send = 1'b0;
        rst          = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
